// File: rtl/pe_pkg.sv
// Shared types and encodings for the pe_sequencer control slice.
package pe_pkg;

   typedef enum logic [2:0] {
      S_FETCH,
      S_DECODE,
      S_EXEC,
      S_MEM,
      S_WB,
      S_TRAP
   } state_e;

   localparam logic [6:0] OPC_OP     = 7'b0110011;
   localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;

   // ALU op is {0, funct7[5], funct3}
   localparam logic [4:0] ALU_ADD  = 5'b00000;
   localparam logic [4:0] ALU_SLL  = 5'b00001;
   localparam logic [4:0] ALU_SLT  = 5'b00010;
   localparam logic [4:0] ALU_SLTU = 5'b00011;
   localparam logic [4:0] ALU_SUB  = 5'b01000;

   localparam logic [1:0] A_RS1  = 2'd0;
   localparam logic [1:0] A_PC   = 2'd1;
   localparam logic [1:0] A_ZERO = 2'd2;
   localparam logic [1:0] B_RS2  = 2'd0;
   localparam logic [1:0] B_IMM  = 2'd1;
   localparam logic [1:0] WB_ALU = 2'd0;
   localparam logic [1:0] WB_MEM = 2'd1;
   localparam logic [1:0] WB_PC4 = 2'd2;

   function automatic logic opc_legal(input logic [6:0] opc);
      case (opc)
         OPC_OP, OPC_OP_IMM, OPC_LOAD, OPC_STORE, OPC_BRANCH,
         OPC_LUI, OPC_AUIPC, OPC_JAL, OPC_JALR: opc_legal = 1'b1;
         default:                               opc_legal = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/pe_imm_gen.sv
// Combinational immediate decoder for I/S/B/U/J formats, sign-extended to XLEN.
module pe_imm_gen
   import pe_pkg::*;
#(
   parameter int XLEN = 32
) (
   input  logic [31:0]     instr,
   output logic [XLEN-1:0] imm
);

   logic [31:0] imm32;

   always_comb begin
      imm32 = '0;
      case (instr[6:0])
         OPC_OP_IMM, OPC_LOAD, OPC_JALR:
            imm32 = {{20{instr[31]}}, instr[31:20]};
         OPC_STORE:
            imm32 = {{20{instr[31]}}, instr[31:25], instr[11:7]};
         OPC_BRANCH:
            imm32 = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
         OPC_LUI, OPC_AUIPC:
            imm32 = {instr[31:12], 12'b0};
         OPC_JAL:
            imm32 = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
         default:
            imm32 = '0;
      endcase
   end

   assign imm = XLEN'($signed(imm32));

endmodule

// File: rtl/pe_sequencer.sv
// Multi-cycle RV32I control sequencer driving an external ALU, register file and memory port.
//
// state  | meaning
// FETCH  | request instruction at pc, latch it on mem_ack
// DECODE | single cycle, illegal opcode traps
// EXEC   | hold ALU operands until alu_done, resolve branch/jump targets
// MEM    | load/store access at latched address
// WB     | one-cycle register write, commit next pc
// TRAP   | sticky fault, left only by rst
module pe_sequencer
   import pe_pkg::*;
#(
   parameter int              XLEN        = 32,
   parameter logic [XLEN-1:0] RESET_PC    = '0,
   parameter int              MEM_TIMEOUT = 15
) (
   input  logic            clk,
   input  logic            rst,
   input  logic [31:0]     instr,
   input  logic            mem_ack,
   input  logic            alu_done,
   input  logic            alu_zero,
   input  logic [XLEN-1:0] alu_res,
   output logic [XLEN-1:0] pc,
   output logic            ir_en,
   output logic [4:0]      alu_sel,
   output logic [1:0]      a_sel,
   output logic [1:0]      b_sel,
   output logic [XLEN-1:0] imm,
   output logic [4:0]      rs1_addr,
   output logic [4:0]      rs2_addr,
   output logic [4:0]      rd_addr,
   output logic            rd_we,
   output logic [1:0]      wb_sel,
   output logic            mem_req,
   output logic            mem_we,
   output logic [XLEN-1:0] mem_addr,
   output logic [1:0]      mem_size,
   output logic            trap
);

   localparam int CW = $clog2(MEM_TIMEOUT + 1);

   state_e          state, state_nxt;
   logic [31:0]     ir, ir_nxt;
   logic [XLEN-1:0] pc_nxt, npc, npc_nxt, maddr, maddr_nxt, target;
   logic [CW-1:0]   wait_cnt, wait_cnt_nxt;
   logic [6:0]      opc;
   logic [2:0]      f3;
   logic            taken, active, wait_expired;

   assign opc          = ir[6:0];
   assign f3           = ir[14:12];
   assign rs1_addr     = ir[19:15];
   assign rs2_addr     = ir[24:20];
   assign rd_addr      = ir[11:7];
   assign trap         = (state == S_TRAP);
   assign wait_expired = (wait_cnt == CW'(MEM_TIMEOUT - 1));
   assign active       = !rst && (state inside {S_DECODE, S_EXEC, S_MEM, S_WB});

   pe_imm_gen #(.XLEN(XLEN)) u_imm_gen (
      .instr (ir),
      .imm   (imm)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state    <= S_FETCH;
         pc       <= RESET_PC;
         ir       <= '0;
         npc      <= '0;
         maddr    <= '0;
         wait_cnt <= '0;
      end else begin
         state    <= state_nxt;
         pc       <= pc_nxt;
         ir       <= ir_nxt;
         npc      <= npc_nxt;
         maddr    <= maddr_nxt;
         wait_cnt <= wait_cnt_nxt;
      end
   end

   always_comb begin
      taken = 1'b0;
      case (f3)
         3'b000:         taken = alu_zero;
         3'b001:         taken = !alu_zero;
         3'b100, 3'b110: taken = alu_res[0];
         3'b101, 3'b111: taken = !alu_res[0];
         default:        taken = 1'b0;
      endcase
   end

   always_comb begin
      alu_sel = ALU_ADD;
      a_sel   = A_RS1;
      b_sel   = B_IMM;
      wb_sel  = WB_ALU;
      case (opc)
         OPC_OP: begin
            alu_sel = {1'b0, ir[30], f3};
            b_sel   = B_RS2;
         end
         OPC_OP_IMM: alu_sel = {1'b0, ir[30] & (f3 == 3'b101), f3};
         OPC_BRANCH: begin
            b_sel   = B_RS2;
            alu_sel = f3[2] ? (f3[1] ? ALU_SLTU : ALU_SLT) : ALU_SUB;
         end
         OPC_LUI:   a_sel  = A_ZERO;
         OPC_AUIPC: a_sel  = A_PC;
         OPC_LOAD:  wb_sel = WB_MEM;
         OPC_JAL: begin
            a_sel  = A_PC;
            wb_sel = WB_PC4;
         end
         OPC_JALR:  wb_sel = WB_PC4;
         default: ;
      endcase
      if (!active) begin
         alu_sel = '0;
         a_sel   = '0;
         b_sel   = '0;
         wb_sel  = '0;
      end
   end

   always_comb begin
      state_nxt    = state;
      pc_nxt       = pc;
      ir_nxt       = ir;
      npc_nxt      = npc;
      maddr_nxt    = maddr;
      wait_cnt_nxt = '0;
      target       = '0;
      ir_en        = 1'b0;
      mem_req      = 1'b0;
      mem_we       = 1'b0;
      rd_we        = 1'b0;
      mem_addr     = maddr;
      mem_size     = 2'd0;
      case (state)
         S_FETCH: begin
            mem_req  = 1'b1;
            mem_addr = pc;
            mem_size = 2'd2;
            if (mem_ack) begin
               ir_en     = 1'b1;
               ir_nxt    = instr;
               state_nxt = S_DECODE;
            end else if (wait_expired) begin
               state_nxt = S_TRAP;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         S_DECODE: state_nxt = opc_legal(opc) ? S_EXEC : S_TRAP;
         S_EXEC: begin
            if (alu_done) begin
               npc_nxt = pc + XLEN'(4);
               case (opc)
                  OPC_LOAD, OPC_STORE: begin
                     maddr_nxt = alu_res;
                     state_nxt = S_MEM;
                  end
                  OPC_BRANCH: begin
                     target = taken ? pc + imm : pc + XLEN'(4);
                     if (|target[1:0]) begin
                        state_nxt = S_TRAP;
                     end else begin
                        pc_nxt    = target;
                        state_nxt = S_FETCH;
                     end
                  end
                  OPC_JAL, OPC_JALR: begin
                     // pc+4 for the link is taken from the old pc, so the target waits in npc
                     target    = (opc == OPC_JAL) ? pc + imm : {alu_res[XLEN-1:1], 1'b0};
                     npc_nxt   = target;
                     state_nxt = (|target[1:0]) ? S_TRAP : S_WB;
                  end
                  default: state_nxt = S_WB;
               endcase
            end
         end
         S_MEM: begin
            mem_req  = 1'b1;
            mem_we   = (opc == OPC_STORE);
            mem_size = f3[1:0];
            if (mem_ack) begin
               if (opc == OPC_STORE) begin
                  pc_nxt    = pc + XLEN'(4);
                  state_nxt = S_FETCH;
               end else begin
                  state_nxt = S_WB;
               end
            end else if (wait_expired) begin
               state_nxt = S_TRAP;
            end else begin
               wait_cnt_nxt = wait_cnt + 1'b1;
            end
         end
         S_WB: begin
            rd_we     = (rd_addr != 5'd0);
            pc_nxt    = npc;
            state_nxt = S_FETCH;
         end
         S_TRAP: ;
         default: state_nxt = S_FETCH;
      endcase
      if (rst) begin
         ir_en   = 1'b0;
         mem_req = 1'b0;
         mem_we  = 1'b0;
         rd_we   = 1'b0;
      end
   end

endmodule

// File: tb/tb_pe_sequencer.sv
// Self-checking bench for pe_sequencer: directed scenarios plus random instructions against an instruction-level model.
module tb_pe_sequencer;

   logic        clk = 1'b0;
   logic        rst, mem_ack, alu_done, alu_zero;
   logic [31:0] instr, alu_res;
   logic [31:0] pc, imm, mem_addr;
   logic        ir_en, rd_we, mem_req, mem_we, trap;
   logic [4:0]  alu_sel, rs1_addr, rs2_addr, rd_addr;
   logic [1:0]  a_sel, b_sel, wb_sel, mem_size;

   int          n_chk = 0;
   int          n_err = 0;
   logic [31:0] pc_m;

   always #5 clk = ~clk;

   pe_sequencer #(.XLEN(32), .RESET_PC(32'h0), .MEM_TIMEOUT(15)) dut (
      .clk      (clk),
      .rst      (rst),
      .instr    (instr),
      .mem_ack  (mem_ack),
      .alu_done (alu_done),
      .alu_zero (alu_zero),
      .alu_res  (alu_res),
      .pc       (pc),
      .ir_en    (ir_en),
      .alu_sel  (alu_sel),
      .a_sel    (a_sel),
      .b_sel    (b_sel),
      .imm      (imm),
      .rs1_addr (rs1_addr),
      .rs2_addr (rs2_addr),
      .rd_addr  (rd_addr),
      .rd_we    (rd_we),
      .wb_sel   (wb_sel),
      .mem_req  (mem_req),
      .mem_we   (mem_we),
      .mem_addr (mem_addr),
      .mem_size (mem_size),
      .trap     (trap)
   );

   typedef struct packed {
      logic        legal;
      logic        branch;
      logic        mem_rd;
      logic        mem_wr;
      logic        wr_rd;
      logic        trap;
      logic [4:0]  alu;
      logic [1:0]  a;
      logic [1:0]  b;
      logic [1:0]  wb;
      logic [1:0]  msize;
      logic [31:0] imm;
      logic [31:0] npc;
   } exp_t;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] imm_i(input logic [31:0] i);
      return 32'($signed(i) >>> 20);
   endfunction

   function automatic logic [31:0] imm_s(input logic [31:0] i);
      int v;
      v = int'(i[11:7]) + 32 * int'(i[30:25]) - (i[31] ? 2048 : 0);
      return 32'(v);
   endfunction

   function automatic logic [31:0] imm_b(input logic [31:0] i);
      int v;
      v = 2 * int'(i[11:8]) + 32 * int'(i[30:25]) + 2048 * int'(i[7]) - (i[31] ? 4096 : 0);
      return 32'(v);
   endfunction

   function automatic logic [31:0] imm_j(input logic [31:0] i);
      int v;
      v = 2 * int'(i[30:21]) + 2048 * int'(i[20]) + 4096 * int'(i[19:12]) - (i[31] ? 1048576 : 0);
      return 32'(v);
   endfunction

   // Architectural effect of one instruction: controls seen in DECODE, memory access, write and next pc
   function automatic exp_t model(input logic [31:0] i, input logic [31:0] pc0,
                                  input logic [31:0] res, input logic zero);
      exp_t        e;
      int          f3;
      logic        tk;
      logic [31:0] tgt;
      e       = '0;
      e.legal = 1'b1;
      f3      = int'(i[14:12]);
      e.msize = i[13:12];
      tgt     = pc0 + 32'd4;
      case (i[6:0])
         7'h33: begin e.alu = {2'b00, i[14:12]} | (i[30] ? 5'h08 : 5'h00); e.wr_rd = 1'b1; end
         7'h13: begin
            e.alu = {2'b00, i[14:12]} | ((f3 == 5 && i[30]) ? 5'h08 : 5'h00);
            e.b = 2'd1; e.imm = imm_i(i); e.wr_rd = 1'b1;
         end
         7'h03: begin e.b = 2'd1; e.imm = imm_i(i); e.mem_rd = 1'b1; e.wb = 2'd1; e.wr_rd = 1'b1; end
         7'h23: begin e.b = 2'd1; e.imm = imm_s(i); e.mem_wr = 1'b1; end
         7'h63: begin
            e.branch = 1'b1;
            e.imm    = imm_b(i);
            e.alu    = (f3 < 2) ? 5'h08 : (f3 < 6) ? 5'h02 : 5'h03;
            case (f3)
               0:       tk = zero;
               1:       tk = !zero;
               4, 6:    tk = res[0];
               default: tk = !res[0];
            endcase
            if (tk) tgt = pc0 + e.imm;
         end
         7'h37: begin e.a = 2'd2; e.b = 2'd1; e.imm = i & 32'hFFFFF000; e.wr_rd = 1'b1; end
         7'h17: begin e.a = 2'd1; e.b = 2'd1; e.imm = i & 32'hFFFFF000; e.wr_rd = 1'b1; end
         7'h6F: begin
            e.a = 2'd1; e.b = 2'd1; e.imm = imm_j(i); e.wb = 2'd2; e.wr_rd = 1'b1;
            tgt = pc0 + e.imm;
         end
         7'h67: begin
            e.b = 2'd1; e.imm = imm_i(i); e.wb = 2'd2; e.wr_rd = 1'b1;
            tgt = res & ~32'd1;
         end
         default: e.legal = 1'b0;
      endcase
      e.wr_rd = e.wr_rd & (i[11:7] != 5'd0);
      e.npc   = tgt;
      e.trap  = !e.legal || (tgt % 4 != 0);
      return e;
   endfunction

   function automatic logic [31:0] enc_b(input logic [12:0] im, input logic [2:0] f3);
      return {im[12], im[10:5], 5'd0, 5'd0, f3, im[4:1], im[11], 7'h63};
   endfunction

   function automatic logic [31:0] rand_instr();
      logic [31:0] r;
      int          idx;
      r   = $urandom;
      idx = int'($urandom_range(0, 5));
      case ($urandom_range(0, 9))
         0: return {r[31:7], 7'h33};
         1: return {r[31:7], 7'h13};
         2: return {r[31:15], 3'((idx % 5) < 3 ? (idx % 5) : (idx % 5) + 1), r[11:7], 7'h03};
         3: return {r[31:15], 3'(idx % 3), r[11:7], 7'h23};
         4: return {r[31:15], 3'(idx < 2 ? idx : idx + 2), r[11:7], 7'h63};
         5: return {r[31:7], 7'h37};
         6: return {r[31:7], 7'h17};
         7: return {r[31:7], 7'h6F};
         8: return {r[31:15], 3'b000, r[11:7], 7'h67};
         default: begin
            case (idx % 4)
               0:       return {r[31:7], 7'h7F};
               1:       return {r[31:7], 7'h0F};
               2:       return {r[31:7], 7'h73};
               default: return {r[31:7], 7'h00};
            endcase
         end
      endcase
   endfunction

   task automatic do_reset();
      rst = 1'b1; mem_ack = 1'b0; alu_done = 1'b0;
      tick();
      chk("rst_pc", pc, 32'h0);
      chk("rst_trap", trap, 0);
      chk("rst_mem_req", mem_req, 0);
      chk("rst_mem_we", mem_we, 0);
      chk("rst_ir_en", ir_en, 0);
      chk("rst_rd_we", rd_we, 0);
      chk("rst_alu_sel", alu_sel, 0);
      chk("rst_a_sel", a_sel, 0);
      chk("rst_b_sel", b_sel, 0);
      chk("rst_wb_sel", wb_sel, 0);
      chk("rst_imm", imm, 0);
      rst = 1'b0;
      #1;
      chk("rst_fetch_req", mem_req, 1);
      chk("rst_fetch_addr", mem_addr, 32'h0);
      pc_m = 32'h0;
   endtask

   task automatic run_instr(input logic [31:0] i, input logic [31:0] res, input logic zero,
                            input int fd, input int ed, input int md);
      exp_t e;
      e = model(i, pc_m, res, zero);
      for (int k = 0; k < fd; k++) begin
         mem_ack = 1'b0; alu_done = 1'($urandom_range(0, 1)); instr = $urandom;
         #1;
         chk("fetch_wait_req", mem_req, 1);
         chk("fetch_wait_addr", mem_addr, pc_m);
         chk("fetch_wait_ir_en", ir_en, 0);
         tick();
      end
      alu_done = 1'b0; mem_ack = 1'b1; instr = i;
      #1;
      chk("fetch_ir_en", ir_en, 1);
      chk("fetch_addr", mem_addr, pc_m);
      chk("fetch_we", mem_we, 0);
      tick();
      mem_ack = 1'b0; instr = $urandom;
      #1;
      chk("dec_ir_en", ir_en, 0);
      chk("dec_mem_req", mem_req, 0);
      if (!e.legal) begin
         tick();
         chk("illegal_trap", trap, 1);
         chk("illegal_mem_req", mem_req, 0);
         do_reset();
         return;
      end
      chk("dec_alu_sel", alu_sel, e.alu);
      chk("dec_a_sel", a_sel, e.a);
      chk("dec_b_sel", b_sel, e.b);
      chk("dec_imm", imm, e.imm);
      chk("dec_rd_addr", rd_addr, i[11:7]);
      chk("dec_rs1_addr", rs1_addr, i[19:15]);
      tick();
      for (int k = 0; k < ed; k++) begin
         mem_ack = 1'($urandom_range(0, 1)); alu_res = $urandom;
         #1;
         chk("exec_wait_req", mem_req, 0);
         chk("exec_wait_pc", pc, pc_m);
         tick();
      end
      mem_ack = 1'b0; alu_done = 1'b1; alu_res = res; alu_zero = zero;
      #1;
      chk("exec_alu_sel", alu_sel, e.alu);
      tick();
      alu_done = 1'b0; alu_res = $urandom; alu_zero = 1'($urandom_range(0, 1));
      #1;
      if (e.trap) begin
         chk("exec_trap", trap, 1);
         chk("exec_trap_req", mem_req, 0);
         do_reset();
         return;
      end
      chk("exec_no_trap", trap, 0);
      if (e.branch) begin
         chk("branch_pc", pc, e.npc);
         chk("branch_rd_we", rd_we, 0);
         chk("branch_fetch_req", mem_req, 1);
         pc_m = e.npc;
         return;
      end
      if (e.mem_rd || e.mem_wr) begin
         for (int k = 0; k <= md; k++) begin
            alu_done = 1'($urandom_range(0, 1)); alu_res = $urandom;
            mem_ack = (k == md);
            #1;
            chk("mem_req", mem_req, 1);
            chk("mem_addr", mem_addr, res);
            chk("mem_we", mem_we, e.mem_wr);
            chk("mem_size", mem_size, e.msize);
            tick();
         end
         mem_ack = 1'b0; alu_done = 1'b0;
         #1;
         if (e.mem_wr) begin
            chk("store_pc", pc, e.npc);
            chk("store_rd_we", rd_we, 0);
            chk("store_fetch_addr", mem_addr, e.npc);
            pc_m = e.npc;
            return;
         end
      end
      chk("wb_rd_we", rd_we, e.wr_rd);
      chk("wb_sel", wb_sel, e.wb);
      chk("wb_rd_addr", rd_addr, i[11:7]);
      chk("wb_mem_req", mem_req, 0);
      tick();
      #1;
      chk("wb_rd_we_once", rd_we, 0);
      chk("wb_pc", pc, e.npc);
      chk("wb_fetch_req", mem_req, 1);
      pc_m = e.npc;
   endtask

   initial begin
      rst = 1'b1; mem_ack = 1'b0; alu_done = 1'b0; alu_zero = 1'b0;
      instr = '0; alu_res = '0; pc_m = '0;
      do_reset();

      run_instr(32'h00610113, 32'd8, 1'b0, 0, 1, 0);
      chk("addi_pc", pc, 32'd4);
      run_instr(32'h00611113, 32'd128, 1'b0, 2, 0, 0);
      chk("slli_pc", pc, 32'd8);
      run_instr(32'h00802083, 32'd8, 1'b0, 1, 2, 3);
      chk("lw_pc", pc, 32'd12);
      run_instr(32'h00610113, 32'd0, 1'b0, 0, 0, 0);
      chk("addi_to16_pc", pc, 32'd16);
      run_instr(enc_b(13'h1FF8, 3'b000), 32'd0, 1'b1, 0, 1, 0);
      chk("beq_taken_pc", pc, 32'd8);
      run_instr(32'h00610113, 32'd0, 1'b0, 0, 0, 0);
      run_instr(32'h00610113, 32'd0, 1'b0, 0, 0, 0);
      run_instr(enc_b(13'h1FF8, 3'b000), 32'd5, 1'b0, 0, 0, 0);
      chk("beq_not_taken_pc", pc, 32'd20);
      run_instr(32'h000080E7, 32'd6, 1'b0, 0, 0, 0);
      chk("jalr_misaligned_reset_pc", pc, 32'd0);

      // fetch timeout: 14 silent cycles are tolerated, the 15th traps
      do_reset();
      for (int k = 0; k < 14; k++) begin
         mem_ack = 1'b0;
         tick();
      end
      chk("timeout_14_trap", trap, 0);
      chk("timeout_14_req", mem_req, 1);
      tick();
      chk("timeout_15_trap", trap, 1);
      chk("timeout_15_req", mem_req, 0);
      mem_ack = 1'b1;
      tick();
      chk("trap_sticky", trap, 1);
      chk("trap_ir_en", ir_en, 0);
      chk("trap_rd_we", rd_we, 0);
      mem_ack = 1'b0;
      do_reset();
      chk("trap_cleared", trap, 0);

      // ack arriving on the limit cycle still wins
      for (int k = 0; k < 14; k++) begin
         mem_ack = 1'b0;
         tick();
      end
      mem_ack = 1'b1; instr = 32'h00610113;
      #1;
      chk("limit_ack_ir_en", ir_en, 1);
      tick();
      mem_ack = 1'b0;
      #1;
      chk("limit_ack_no_trap", trap, 0);
      do_reset();

      // reset in the middle of a store
      mem_ack = 1'b1; instr = 32'h00002023;
      tick();
      mem_ack = 1'b0;
      tick();
      alu_done = 1'b1; alu_res = 32'h40;
      tick();
      alu_done = 1'b0;
      #1;
      chk("st_mem_we", mem_we, 1);
      chk("st_mem_addr", mem_addr, 32'h40);
      tick();
      rst = 1'b1;
      #1;
      chk("st_rst_mem_we", mem_we, 0);
      tick();
      rst = 1'b0;
      #1;
      chk("st_rst_fetch_req", mem_req, 1);
      chk("st_rst_fetch_addr", mem_addr, 32'h0);
      chk("st_rst_we", mem_we, 0);
      chk("st_rst_pc", pc, 32'h0);
      pc_m = 32'h0;

      for (int n = 0; n < 40; n++) begin
         run_instr(rand_instr(), $urandom, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, 4)), int'($urandom_range(0, 3)), int'($urandom_range(0, 4)));
      end

      $display("Result: errors=%0d of %0d checks", n_err, n_chk);
      $finish;
   end

endmodule

// File: doc/pe_sequencer.md
PE_SEQUENCER -- requirements
Module: pe_sequencer

Interface
REQ-001 XLEN, 32, datapath/PC width.
REQ-002 RESET_PC, 0, PC value loaded on reset.
REQ-003 MEM_TIMEOUT, 15, max wait cycles for mem_ack before trap (>=1).
REQ-004 clk  input  1  system clock (single clock domain).
REQ-005 rst  input  1  reset; synchronous, active-high.
REQ-006 instr  input  32  fetched instruction; valid with mem_ack in FETCH.
REQ-007 mem_ack  input  1  memory transaction complete.
REQ-008 alu_done  input  1  ALU result valid.
REQ-009 alu_zero  input  1  ALU result equals zero.
REQ-010 alu_res  input  XLEN  ALU result.
REQ-011 pc  output  XLEN  current PC.
REQ-012 ir_en  output  1  instruction-register load strobe.
REQ-013 alu_sel  output  5  ALU operation.
REQ-014 a_sel  output  2  A operand: 0 rs1, 1 PC, 2 zero.
REQ-015 b_sel  output  2  B operand: 0 rs2, 1 imm.
REQ-016 imm  output  XLEN  sign-extended immediate.
REQ-017 rs1_addr, rs2_addr, rd_addr  output  5 each  register indices.
REQ-018 rd_we  output  1  register-file write strobe.
REQ-019 wb_sel  output  2  writeback source: 0 ALU, 1 memory, 2 PC+4.
REQ-020 mem_req, mem_we  output  1 each  memory request / write.
REQ-021 mem_addr  output  XLEN  memory address.
REQ-022 mem_size  output  2  0 byte, 1 half, 2 word (funct3[1:0]).
REQ-023 trap  output  1  sticky fault indicator.

Function
REQ-024 FSM states FETCH, DECODE, EXEC, MEM, WB, TRAP; one transition max per cycle.
REQ-025 FETCH: mem_req=1, mem_we=0, mem_addr=pc; on mem_ack latch instr, ir_en=1 that cycle, go DECODE.
REQ-026 DECODE: one cycle; opcodes outside {OP, OP-IMM, LOAD, STORE, BRANCH, LUI, AUIPC, JAL, JALR} go TRAP.
REQ-027 alu_sel = {funct7[5] for OP and SRAI/SRLI else 0, funct3} for OP/OP-IMM; ADD for LOAD/STORE/AUIPC/LUI/JALR; SUB for BEQ/BNE, SLT for BLT/BGE, SLTU for BLTU/BGEU.
REQ-028 EXEC: hold operands until alu_done; then LOAD/STORE go MEM with mem_addr latched from alu_res; OP/OP-IMM/LUI/AUIPC go WB.
REQ-029 BRANCH taken: BEQ alu_zero, BNE !alu_zero, BLT/BLTU alu_res[0], BGE/BGEU !alu_res[0]; taken pc<=pc+imm else pc+4; go FETCH.
REQ-030 JAL target pc+imm, JALR target alu_res with bit0 cleared; wb_sel=2; go WB.
REQ-031 MEM: mem_req held until mem_ack; store mem_we=1, then pc+4, FETCH; load go WB, wb_sel=1.
REQ-032 WB: rd_we=1 for exactly one cycle, suppressed when rd_addr=0; pc updated; go FETCH.
REQ-033 Wait counter counts FETCH/MEM cycles without ack; reaching MEM_TIMEOUT goes TRAP; ack in same cycle as limit wins.
REQ-034 New pc with bits[1:0]!=0 goes TRAP instead of FETCH.
REQ-035 TRAP: trap=1; mem_req, rd_we, ir_en 0; remains until rst.
REQ-036 mem_ack outside FETCH/MEM and alu_done outside EXEC ignored.
REQ-037 PC arithmetic modulo 2^XLEN.

Reset
REQ-038 On rst sampled high: pc=RESET_PC, state FETCH, IR=0, counter=0, trap=0, all strobes 0, all selects 0.
REQ-039 rst mid-transaction abandons it; next cycle issues fresh fetch at RESET_PC.

Structure
REQ-040 Package pe_pkg holds state enum, opcode constants, ALU op codes, a_sel/b_sel/wb_sel encodings.
REQ-041 Immediate decode in sub-module pe_imm_gen (combinational, I/S/B/U/J formats).

Verification
REQ-042 ADDI x2,x2,6 (0x00610113) from pc=0, ack, alu_done -> imm=6, b_sel=1, alu_sel=ADD, rd_we pulse rd=2, pc=4.
REQ-043 SLLI x2,x2,6 (0x00611113) -> alu_sel=SLL, imm=6, rd_we rd=2, pc advances 4.
REQ-044 LW x1,8(x0), alu_res=8 -> MEM mem_addr=8, mem_size=2, then WB wb_sel=1 rd=1.
REQ-045 BEQ at pc=16, imm=-8, alu_zero=1 -> pc=8, no rd_we; alu_zero=0 -> pc=20.
REQ-046 mem_ack withheld 15 cycles in FETCH -> trap=1, mem_req=0, persists; rst -> pc=RESET_PC, FETCH.
REQ-047 rst asserted during MEM of a store -> no further mem_we, next fetch at RESET_PC.
